register_file: RTL and testbench



---
 rtl/rv_pkg.sv | 10 +
 rtl/register_file.sv | 47 ++++
 tb/tb_register_file.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 integer datapath constants, reused by decode, ALU, writeback and the register file.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file.sv
// Integer register file: 2 combinational read ports, 1 synchronous write port, x0 hardwired to 0.
module register_file
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  regwrite,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_regs [Depth];
  logic                  w_we;
  logic                  w_rd1_zero;
  logic                  w_rd2_zero;

  // Write path is masked so x0 storage never holds nonzero data.
  assign w_we = regwrite && (write_reg != ZeroIdx);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Read-side forcing keeps x0 at 0 even before the first reset edge.
  assign w_rd1_zero = (read_reg_1 == ZeroIdx);
  assign w_rd2_zero = (read_reg_2 == ZeroIdx);

  assign read_data1 = w_rd1_zero ? '0 : r_regs[read_reg_1];
  assign read_data2 = w_rd2_zero ? '0 : r_regs[read_reg_2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regwrite;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int total;
  int bad;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .read_reg_1 (read_reg_1),
    .read_reg_2 (read_reg_2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regwrite   (regwrite),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge, leaving margin before inputs change.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    regwrite   = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'h0;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    #1;
    chk("x0_before_reset", read_data1, 32'h0);

    // Reset
    tick();
    reset      = 1'b0;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd2;
    #1;
    chk("reset_rd1_x0", read_data1, 32'h0);
    chk("reset_rd2_x2", read_data2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read_reg_1 = 5'(i);
      read_reg_2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_sweep_rd1_x%0d", i), read_data1, 32'h0);
      chk($sformatf("reset_sweep_rd2_x%0d", 31 - i), read_data2, 32'h0);
    end

    // x0 write ignored
    regwrite   = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'hFFFF_FFFF;
    tick();
    read_reg_1 = 5'd0;
    #1;
    chk("x0_write_ignored", read_data1, 32'h0);

    // Basic write/read
    write_reg  = 5'd1;
    write_data = 32'd30;
    tick();
    read_reg_1 = 5'd1;
    read_reg_2 = 5'd1;
    #1;
    chk("x1_rd1", read_data1, 32'd30);
    chk("x1_rd2", read_data2, 32'd30);
    read_reg_2 = 5'd2;
    #1;
    chk("x2_untouched", read_data2, 32'h0);

    // Same-cycle read of the register being written: old value until the edge
    read_reg_1 = 5'd5;
    write_reg  = 5'd5;
    write_data = 32'h1234_5678;
    #1;
    chk("x5_old_before_edge", read_data1, 32'h0);
    tick();
    chk("x5_new_after_edge", read_data1, 32'h1234_5678);

    // Write enable low
    regwrite   = 1'b0;
    write_reg  = 5'd1;
    write_data = 32'd99;
    tick();
    read_reg_1 = 5'd1;
    #1;
    chk("x1_we_low", read_data1, 32'd30);

    // Top index and idempotent rewrite
    regwrite   = 1'b1;
    write_reg  = 5'd31;
    write_data = 32'hA5A5_A5A5;
    tick();
    tick();
    read_reg_2 = 5'd31;
    #1;
    chk("x31_write", read_data2, 32'hA5A5_A5A5);
    read_reg_1 = 5'd5;
    #1;
    chk("x5_kept", read_data1, 32'h1234_5678);

    // Reset priority over a same-edge write
    reset      = 1'b1;
    regwrite   = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'd7;
    tick();
    reset      = 1'b0;
    regwrite   = 1'b0;
    read_reg_1 = 5'd1;
    read_reg_2 = 5'd3;
    #1;
    chk("rst_prio_x1", read_data1, 32'h0);
    chk("rst_prio_x3", read_data2, 32'h0);
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd31;
    #1;
    chk("rst_prio_x5", read_data1, 32'h0);
    chk("rst_prio_x31", read_data2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
